// File: rtl/reorder_buffer_pkg.sv
// Shared definitions for the reorder buffer: sizes, opcode encodings,
// the per-entry record and the opcode class helpers.
package reorder_buffer_pkg;

  localparam int ROB_SIZE_LOG = 4;
  localparam int OP_SIZE_LOG  = 6;
  localparam int ROB_SIZE     = 1 << ROB_SIZE_LOG;
  localparam logic [ROB_SIZE_LOG:0] ROB_CAP = (ROB_SIZE_LOG + 1)'(ROB_SIZE);

  typedef logic [OP_SIZE_LOG-1:0]  op_t;
  typedef logic [ROB_SIZE_LOG-1:0] robid_t;

  localparam op_t OP_NOP   = 6'd0;
  localparam op_t OP_LUI   = 6'd1;
  localparam op_t OP_AUIPC = 6'd2;
  localparam op_t OP_JAL   = 6'd3;
  localparam op_t OP_JALR  = 6'd4;
  localparam op_t OP_BEQ   = 6'd5;
  localparam op_t OP_BNE   = 6'd6;
  localparam op_t OP_BLT   = 6'd7;
  localparam op_t OP_BGE   = 6'd8;
  localparam op_t OP_BLTU  = 6'd9;
  localparam op_t OP_BGEU  = 6'd10;
  localparam op_t OP_LB    = 6'd11;
  localparam op_t OP_LH    = 6'd12;
  localparam op_t OP_LW    = 6'd13;
  localparam op_t OP_LBU   = 6'd14;
  localparam op_t OP_LHU   = 6'd15;
  localparam op_t OP_SB    = 6'd16;
  localparam op_t OP_SH    = 6'd17;
  localparam op_t OP_SW    = 6'd18;
  localparam op_t OP_ADDI  = 6'd19;
  localparam op_t OP_ADD   = 6'd20;

  typedef struct packed {
    logic        busy;
    logic        ready;
    op_t         op;
    logic [4:0]  rd;
    logic        pred_jump;
    logic [31:0] value;
    logic        jump;
    logic [31:0] target;
  } rob_entry_t;

  function automatic logic is_store(input op_t op);
    return (op >= OP_SB) && (op <= OP_SW);
  endfunction

  function automatic logic is_branch(input op_t op);
    return (op >= OP_BEQ) && (op <= OP_BGEU);
  endfunction

endpackage

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates ids at issue, captures CDB results,
// answers operand queries and retires in program order with mispredict flush.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rdy,
  input  logic                    issue_enable,
  input  logic [ROB_SIZE_LOG-1:0] issue_robid,
  input  logic [OP_SIZE_LOG-1:0]  issue_op,
  input  logic [4:0]              issue_rd,
  input  logic                    issue_pred_jump,
  output logic [ROB_SIZE_LOG-1:0] next_robid,
  output logic                    rob_full,
  input  logic [ROB_SIZE_LOG-1:0] rs1_query_id,
  input  logic [ROB_SIZE_LOG-1:0] rs2_query_id,
  output logic                    rob_rs1_ready,
  output logic                    rob_rs2_ready,
  output logic [31:0]             rob_rs1_value,
  output logic [31:0]             rob_rs2_value,
  input  logic                    alu_cdb_enable,
  input  logic [ROB_SIZE_LOG-1:0] alu_cdb_robid,
  input  logic [31:0]             alu_cdb_value,
  input  logic                    alu_cdb_jump,
  input  logic [31:0]             alu_cdb_target,
  input  logic                    lsb_cdb_enable,
  input  logic [ROB_SIZE_LOG-1:0] lsb_cdb_robid,
  input  logic [31:0]             lsb_cdb_value,
  output logic                    commit_enable,
  output logic [ROB_SIZE_LOG-1:0] commit_robid,
  output logic [4:0]              commit_rd,
  output logic [31:0]             commit_value,
  output logic                    store_commit_enable,
  output logic                    clear,
  output logic [31:0]             clear_pc
);

  rob_entry_t            entries [ROB_SIZE];
  robid_t                head;
  robid_t                tail;
  logic [ROB_SIZE_LOG:0] count;
  rob_entry_t            head_e;
  logic                  do_commit;
  logic                  do_issue;
  logic                  mispredict;

  // Issue handshake: the issue stage offers an entry with issue_enable and the
  // id it read from next_robid; it is taken when the ROB has room (or the head
  // retires the same cycle), rdy is high, and no flush is being signalled.
  assign head_e     = entries[head];
  assign next_robid = tail;
  assign rob_full   = (count == ROB_CAP);
  assign do_commit  = rdy && head_e.busy && head_e.ready;
  assign mispredict = do_commit && (is_branch(head_e.op) || head_e.op == OP_JALR)
                      && (head_e.jump != head_e.pred_jump);
  assign do_issue   = rdy && issue_enable && (issue_robid == tail)
                      && (!rob_full || do_commit) && !clear;

  // ALU broadcast has priority over LSB, and both over the stored value.
  always_comb begin
    rob_rs1_ready = entries[rs1_query_id].ready;
    rob_rs1_value = entries[rs1_query_id].value;
    if (lsb_cdb_enable && lsb_cdb_robid == rs1_query_id) begin
      rob_rs1_ready = 1'b1;
      rob_rs1_value = lsb_cdb_value;
    end
    if (alu_cdb_enable && alu_cdb_robid == rs1_query_id) begin
      rob_rs1_ready = 1'b1;
      rob_rs1_value = alu_cdb_value;
    end
    rob_rs2_ready = entries[rs2_query_id].ready;
    rob_rs2_value = entries[rs2_query_id].value;
    if (lsb_cdb_enable && lsb_cdb_robid == rs2_query_id) begin
      rob_rs2_ready = 1'b1;
      rob_rs2_value = lsb_cdb_value;
    end
    if (alu_cdb_enable && alu_cdb_robid == rs2_query_id) begin
      rob_rs2_ready = 1'b1;
      rob_rs2_value = alu_cdb_value;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head                <= '0;
      tail                <= '0;
      count               <= '0;
      commit_enable       <= 1'b0;
      commit_robid        <= '0;
      commit_rd           <= '0;
      commit_value        <= '0;
      store_commit_enable <= 1'b0;
      clear               <= 1'b0;
      clear_pc            <= '0;
      for (int i = 0; i < ROB_SIZE; i++) entries[i] <= '0;
    end else if (!rdy) begin
      commit_enable       <= 1'b0;
      store_commit_enable <= 1'b0;
      clear               <= 1'b0;
    end else begin
      commit_enable       <= do_commit;
      store_commit_enable <= do_commit && is_store(head_e.op);
      clear               <= mispredict;
      if (do_commit) begin
        commit_robid <= head;
        commit_rd    <= (is_store(head_e.op) || is_branch(head_e.op)) ? 5'd0 : head_e.rd;
        commit_value <= head_e.value;
      end
      if (mispredict) clear_pc <= head_e.target;

      if (alu_cdb_enable) begin
        entries[alu_cdb_robid].value  <= alu_cdb_value;
        entries[alu_cdb_robid].jump   <= alu_cdb_jump;
        entries[alu_cdb_robid].target <= alu_cdb_target;
        entries[alu_cdb_robid].ready  <= 1'b1;
      end
      if (lsb_cdb_enable) begin
        entries[lsb_cdb_robid].value <= lsb_cdb_value;
        entries[lsb_cdb_robid].ready <= 1'b1;
      end

      // Retire before allocate so a full ROB can recycle the head slot.
      if (do_commit) entries[head].busy <= 1'b0;
      if (do_issue) begin
        entries[tail] <= '{busy: 1'b1, ready: 1'b0, op: issue_op, rd: issue_rd,
                           pred_jump: issue_pred_jump, value: '0, jump: 1'b0,
                           target: '0};
        tail <= tail + robid_t'(1);
      end
      count <= count + {{ROB_SIZE_LOG{1'b0}}, do_issue} - {{ROB_SIZE_LOG{1'b0}}, do_commit};
      if (do_commit) head <= head + robid_t'(1);

      if (mispredict) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
        for (int i = 0; i < ROB_SIZE; i++) entries[i].busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: expected retire records are queued as
// stimulus is issued and a negedge monitor compares every commit/clear pulse.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  localparam int REC_W = 76;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        rdy = 1'b1;
  logic        issue_enable = 1'b0;
  logic [3:0]  issue_robid = '0;
  logic [5:0]  issue_op = '0;
  logic [4:0]  issue_rd = '0;
  logic        issue_pred_jump = 1'b0;
  logic [3:0]  next_robid;
  logic        rob_full;
  logic [3:0]  rs1_query_id = '0;
  logic [3:0]  rs2_query_id = '0;
  logic        rob_rs1_ready, rob_rs2_ready;
  logic [31:0] rob_rs1_value, rob_rs2_value;
  logic        alu_cdb_enable = 1'b0;
  logic [3:0]  alu_cdb_robid = '0;
  logic [31:0] alu_cdb_value = '0;
  logic        alu_cdb_jump = 1'b0;
  logic [31:0] alu_cdb_target = '0;
  logic        lsb_cdb_enable = 1'b0;
  logic [3:0]  lsb_cdb_robid = '0;
  logic [31:0] lsb_cdb_value = '0;
  logic        commit_enable;
  logic [3:0]  commit_robid;
  logic [4:0]  commit_rd;
  logic [31:0] commit_value;
  logic        store_commit_enable;
  logic        clear;
  logic [31:0] clear_pc;

  int n_vec = 0;
  int n_err = 0;
  logic [REC_W-1:0] exp_q[$];

  reorder_buffer dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .issue_enable(issue_enable), .issue_robid(issue_robid), .issue_op(issue_op),
    .issue_rd(issue_rd), .issue_pred_jump(issue_pred_jump),
    .next_robid(next_robid), .rob_full(rob_full),
    .rs1_query_id(rs1_query_id), .rs2_query_id(rs2_query_id),
    .rob_rs1_ready(rob_rs1_ready), .rob_rs2_ready(rob_rs2_ready),
    .rob_rs1_value(rob_rs1_value), .rob_rs2_value(rob_rs2_value),
    .alu_cdb_enable(alu_cdb_enable), .alu_cdb_robid(alu_cdb_robid),
    .alu_cdb_value(alu_cdb_value), .alu_cdb_jump(alu_cdb_jump),
    .alu_cdb_target(alu_cdb_target),
    .lsb_cdb_enable(lsb_cdb_enable), .lsb_cdb_robid(lsb_cdb_robid),
    .lsb_cdb_value(lsb_cdb_value),
    .commit_enable(commit_enable), .commit_robid(commit_robid),
    .commit_rd(commit_rd), .commit_value(commit_value),
    .store_commit_enable(store_commit_enable), .clear(clear), .clear_pc(clear_pc)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // Record: {commit, clear, clear_pc, store, robid, rd, value}
  function automatic logic [REC_W-1:0] rec(input logic clr, input logic [31:0] pc,
                                           input logic st, input logic [3:0] id,
                                           input logic [4:0] rd, input logic [31:0] val);
    return {1'b1, clr, pc, st, id, rd, val};
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [REC_W-1:0] act;
    logic [REC_W-1:0] exp;
    if (rst_n && (commit_enable || clear || store_commit_enable)) begin
      act = {commit_enable, clear, clear ? clear_pc : 32'h0, store_commit_enable,
             commit_robid, commit_rd, commit_value};
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_retire: got %h, none expected", act);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          n_err++;
          $display("FAIL retire_record: got %h expected %h", act, exp);
        end
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_issue(input logic [5:0] op, input logic [4:0] rd, input logic pj);
    issue_enable    = 1'b1;
    issue_robid     = next_robid;
    issue_op        = op;
    issue_rd        = rd;
    issue_pred_jump = pj;
    tick();
    issue_enable    = 1'b0;
  endtask

  task automatic alu_wb(input logic [3:0] id, input logic [31:0] val,
                        input logic jmp, input logic [31:0] tgt);
    alu_cdb_enable = 1'b1;
    alu_cdb_robid  = id;
    alu_cdb_value  = val;
    alu_cdb_jump   = jmp;
    alu_cdb_target = tgt;
    tick();
    alu_cdb_enable = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int budget = 100;
    while (exp_q.size() != 0 && budget > 0) begin
      tick();
      budget--;
    end
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    // Reset
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_commit_enable", commit_enable, 0);
    check("rst_clear", clear, 0);
    check("rst_next_robid", next_robid, 0);
    check("rst_rob_full", rob_full, 0);
    check("rst_rs1_ready", rob_rs1_ready, 0);
    check("rst_rs1_value", rob_rs1_value, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Fill 16, wrap, overflow issue ignored, then drain in order
    for (int i = 0; i < 16; i++) drive_issue(OP_ADD, 5'(i + 1), 1'b0);
    check("full_after_16", rob_full, 1);
    check("wrap_next_robid", next_robid, 0);
    drive_issue(OP_ADD, 5'd31, 1'b0);
    check("full_after_17th", rob_full, 1);
    check("next_robid_after_17th", next_robid, 0);
    for (int i = 0; i < 16; i++) exp_q.push_back(rec(1'b0, 32'h0, 1'b0, 4'(i), 5'(i + 1), 32'(100 + i)));
    for (int i = 0; i < 16; i++) alu_wb(4'(i), 32'(100 + i), 1'b0, 32'h0);
    wait_drain("drain_fill");
    check("empty_after_drain", rob_full, 0);
    check("next_robid_after_drain", next_robid, 0);

    // Out-of-order writeback, in-order commit, two-cycle latency
    drive_issue(OP_ADD, 5'd3, 1'b0);
    drive_issue(OP_ADD, 5'd4, 1'b0);
    exp_q.push_back(rec(1'b0, 32'h0, 1'b0, 4'd0, 5'd3, 32'd7));
    exp_q.push_back(rec(1'b0, 32'h0, 1'b0, 4'd1, 5'd4, 32'd5));
    alu_wb(4'd1, 32'd5, 1'b0, 32'h0);
    alu_wb(4'd0, 32'd7, 1'b0, 32'h0);
    check("lat_t1_commit_low", commit_enable, 0);
    tick();
    check("lat_t2_commit_high", commit_enable, 1);
    check("lat_t2_commit_robid", commit_robid, 0);
    check("lat_t2_commit_value", commit_value, 7);
    wait_drain("drain_order");

    // CDB bypass on query, dual-port writeback, store retire
    drive_issue(OP_LW, 5'd6, 1'b0);
    drive_issue(OP_LW, 5'd7, 1'b0);
    drive_issue(OP_SW, 5'd9, 1'b0);
    exp_q.push_back(rec(1'b0, 32'h0, 1'b0, 4'd2, 5'd6, 32'h1234));
    exp_q.push_back(rec(1'b0, 32'h0, 1'b0, 4'd3, 5'd7, 32'hDEAD));
    exp_q.push_back(rec(1'b0, 32'h0, 1'b1, 4'd4, 5'd0, 32'h44));
    rs1_query_id   = 4'd3;
    rs2_query_id   = 4'd2;
    lsb_cdb_enable = 1'b1;
    lsb_cdb_robid  = 4'd3;
    lsb_cdb_value  = 32'hDEAD;
    #1;
    check("bypass_rs1_ready", rob_rs1_ready, 1);
    check("bypass_rs1_value", rob_rs1_value, 32'hDEAD);
    check("bypass_rs2_not_ready", rob_rs2_ready, 0);
    tick();
    lsb_cdb_enable = 1'b0;
    #1;
    check("stored_rs1_ready", rob_rs1_ready, 1);
    check("stored_rs1_value", rob_rs1_value, 32'hDEAD);
    alu_cdb_enable = 1'b1;
    alu_cdb_robid  = 4'd2;
    alu_cdb_value  = 32'h1234;
    alu_cdb_jump   = 1'b0;
    lsb_cdb_enable = 1'b1;
    lsb_cdb_robid  = 4'd4;
    lsb_cdb_value  = 32'h44;
    tick();
    alu_cdb_enable = 1'b0;
    lsb_cdb_enable = 1'b0;
    wait_drain("drain_store");

    // Mispredicted branch: retire, clear pulse, flush younger entry
    exp_q.push_back(rec(1'b1, 32'h100, 1'b0, 4'd5, 5'd0, 32'h0));
    drive_issue(OP_BEQ, 5'd12, 1'b0);
    drive_issue(OP_ADD, 5'd13, 1'b0);
    alu_wb(4'd6, 32'h66, 1'b0, 32'h0);
    alu_wb(4'd5, 32'h0, 1'b1, 32'h100);
    tick();
    check("clear_pulse", clear, 1);
    check("clear_pc", clear_pc, 32'h100);
    check("flush_next_robid", next_robid, 0);
    check("flush_rob_full", rob_full, 0);
    drive_issue(OP_ADD, 5'd1, 1'b0);
    check("clear_one_cycle", clear, 0);
    check("no_issue_after_clear", next_robid, 0);
    wait_drain("drain_flush");

    // Full ROB: commit and allocate in the same cycle
    for (int i = 0; i < 16; i++) drive_issue(OP_ADD, 5'(i + 1), 1'b0);
    exp_q.push_back(rec(1'b0, 32'h0, 1'b0, 4'd0, 5'd1, 32'h55));
    alu_wb(4'd0, 32'h55, 1'b0, 32'h0);
    drive_issue(OP_ADD, 5'd20, 1'b0);
    check("full_swap_rob_full", rob_full, 1);
    check("full_swap_next_robid", next_robid, 1);
    for (int i = 1; i < 16; i++) exp_q.push_back(rec(1'b0, 32'h0, 1'b0, 4'(i), 5'(i + 1), 32'(32'h200 + i)));
    exp_q.push_back(rec(1'b0, 32'h0, 1'b0, 4'd0, 5'd20, 32'h77));
    for (int i = 1; i < 16; i++) alu_wb(4'(i), 32'(32'h200 + i), 1'b0, 32'h0);
    alu_wb(4'd0, 32'h77, 1'b0, 32'h0);
    wait_drain("drain_full_swap");
    check("full_swap_drained", rob_full, 0);
    check("full_swap_final_tail", next_robid, 1);

    // rdy low freezes state, then reset mid-stream with 5 busy entries
    rdy = 1'b0;
    drive_issue(OP_ADD, 5'd2, 1'b0);
    rdy = 1'b1;
    check("rdy_low_freeze", next_robid, 1);
    for (int i = 0; i < 5; i++) drive_issue(OP_ADD, 5'(i + 1), 1'b0);
    check("five_busy_tail", next_robid, 6);
    rs1_query_id   = 4'd2;
    lsb_cdb_enable = 1'b1;
    lsb_cdb_robid  = 4'd2;
    lsb_cdb_value  = 32'hABC;
    tick();
    lsb_cdb_enable = 1'b0;
    #1;
    check("pre_reset_rs1_ready", rob_rs1_ready, 1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_next_robid", next_robid, 0);
    check("async_rst_rs1_ready", rob_rs1_ready, 0);
    check("async_rst_rs1_value", rob_rs1_value, 0);
    check("async_rst_commit", commit_enable, 0);
    check("async_rst_clear_pc", clear_pc, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("post_rst_next_robid", next_robid, 0);
    check("post_rst_rob_full", rob_full, 0);
    repeat (3) tick();
    check("post_rst_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
